// File: rtl/tl_ul_protocol_checker.sv
// ============================================================================
// tl_ul_protocol_checker
//
// Passive TileLink-UL/UH A/D channel protocol checker. It sits beside a
// client/manager link in a testbench and never drives the bus. It tracks
// in-flight sources, multi-beat bursts, request/response matching and
// response latency. Violations accumulate on sticky error flags.
//
// Error classes (err_sticky bit index; err_first reports index + 1):
//   0  illegal A opcode or param
//   1  A address misaligned to size, or partial mask on a full-lane Get/PutFull
//   2  A request on a source that is already in flight
//   3  A later beat differs from the first-beat opcode/param/size/source/address
//   4  D response for a source that is not in flight
//   5  D opcode or size does not match the outstanding request
//   6  D later beat differs from the first-beat opcode/size/source
//   7  no D progress for WATCHDOG_CYCLES while requests are in flight
//   8  A valid dropped or A payload changed while stalled
//
// Ports:
//   clock, reset_n        sole clock; synchronous active-low reset
//   a_valid .. a_mask     observed A channel (valid/ready handshake + payload)
//   d_valid .. d_denied   observed D channel (d_denied is observed, not checked)
//   err_sticky[8:0]       OR-accumulated error classes
//   err_pulse             high for one cycle after any cycle with a new error
//   err_first[3:0]        class index + 1 of the first error seen, 0 = none
//   inflight_cnt          number of sources currently awaiting a response
//
// Optional build macro TL_UL_CHECKER_FATAL_EN: every new error also issues
// $error naming the class, source and cycle count; classes 2, 4 and 7 then
// call $fatal. Without the macro the checker only raises flags.
// ============================================================================
module tl_ul_protocol_checker #(
    parameter int SOURCE_BITS     = 7,
    parameter int ADDR_BITS       = 25,
    parameter int SIZE_BITS       = 3,
    parameter int BEAT_LOG2       = 3,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        a_valid,
    input  logic                        a_ready,
    input  logic [2:0]                  a_opcode,
    input  logic [2:0]                  a_param,
    input  logic [SIZE_BITS-1:0]        a_size,
    input  logic [SOURCE_BITS-1:0]      a_source,
    input  logic [ADDR_BITS-1:0]        a_address,
    input  logic [(1<<BEAT_LOG2)-1:0]   a_mask,
    input  logic                        d_valid,
    input  logic                        d_ready,
    input  logic [2:0]                  d_opcode,
    input  logic [SIZE_BITS-1:0]        d_size,
    input  logic [SOURCE_BITS-1:0]      d_source,
    input  logic                        d_denied,
    output logic [8:0]                  err_sticky,
    output logic                        err_pulse,
    output logic [3:0]                  err_first,
    output logic [SOURCE_BITS:0]        inflight_cnt
);

    localparam int NSRC   = 1 << SOURCE_BITS;
    localparam int MASK_W = 1 << BEAT_LOG2;
    localparam int BW     = 1 << SIZE_BITS;
    localparam int WD_W   = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [2:0] A_PUTFULL    = 3'd0;
    localparam logic [2:0] A_PUTPARTIAL = 3'd1;
    localparam logic [2:0] A_ARITH      = 3'd2;
    localparam logic [2:0] A_LOGICAL    = 3'd3;
    localparam logic [2:0] A_GET        = 3'd4;
    localparam logic [2:0] A_HINT       = 3'd5;
    localparam logic [2:0] D_ACK        = 3'd0;
    localparam logic [2:0] D_ACKDATA    = 3'd1;
    localparam logic [2:0] D_HINTACK    = 3'd2;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic a_has_data(input logic [2:0] op);
        return (op == A_PUTFULL) || (op == A_PUTPARTIAL) ||
               (op == A_ARITH) || (op == A_LOGICAL);
    endfunction

    function automatic logic a_wants_data(input logic [2:0] op);
        return (op == A_GET) || (op == A_ARITH) || (op == A_LOGICAL);
    endfunction

    // Index of the last beat: beats - 1, where beats = max(1, 2^size >> BEAT_LOG2)
    // for data-carrying messages and 1 otherwise.
    function automatic logic [BW-1:0] last_beat(input logic data,
                                                input logic [SIZE_BITS-1:0] size);
        logic [BW-1:0] one;
        one       = BW'(1);
        last_beat = '0;
        if (data && (int'(size) > BEAT_LOG2))
            last_beat = (one << (int'(size) - BEAT_LOG2)) - one;
    endfunction

    function automatic logic param_illegal(input logic [2:0] op, input logic [2:0] prm);
        logic bad;
        case (op)
            A_PUTFULL, A_PUTPARTIAL, A_GET: bad = (prm != 3'd0);
            A_ARITH:                        bad = (prm > 3'd4);
            A_LOGICAL:                      bad = (prm > 3'd3);
            A_HINT:                         bad = (prm > 3'd1);
            default:                        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [2:0] d_expected(input logic want_data, input logic hint_req);
        if (want_data)
            return D_ACKDATA;
        else if (hint_req)
            return D_HINTACK;
        else
            return D_ACK;
    endfunction

    function automatic logic [3:0] first_code(input logic [8:0] e);
        logic [3:0] code;
        code = '0;
        for (int i = 8; i >= 0; i--)
            if (e[i]) code = 4'(i + 1);
        return code;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [BW-1:0]           r_a_beat;
    logic [2:0]              r_a_opcode;
    logic [2:0]              r_a_param;
    logic [SIZE_BITS-1:0]    r_a_size;
    logic [SOURCE_BITS-1:0]  r_a_source;
    logic [ADDR_BITS-1:0]    r_a_address;

    logic [BW-1:0]           r_d_beat;
    logic [2:0]              r_d_opcode;
    logic [SIZE_BITS-1:0]    r_d_size;
    logic [SOURCE_BITS-1:0]  r_d_source;

    logic                    r_a_pend;
    logic [2:0]              r_snap_opcode;
    logic [2:0]              r_snap_param;
    logic [SIZE_BITS-1:0]    r_snap_size;
    logic [SOURCE_BITS-1:0]  r_snap_source;
    logic [ADDR_BITS-1:0]    r_snap_address;
    logic [MASK_W-1:0]       r_snap_mask;

    logic [NSRC-1:0]         r_inflight;
    logic [NSRC-1:0]         r_expect;
    logic [NSRC-1:0]         r_is_hint;
    logic [SIZE_BITS-1:0]    r_src_size [NSRC];

    logic [SOURCE_BITS:0]    r_cnt;
    logic [WD_W-1:0]         r_wd;

    logic [8:0]              r_err_sticky_p1;
    logic                    r_err_pulse_p1;
    logic [3:0]              r_err_first_p1;

    // ------------------------------------------------------------------------
    // Stage p0: combinational decode and checks on the current inputs
    // ------------------------------------------------------------------------
    logic                    w_fire_a;
    logic                    w_fire_d;
    logic                    w_a_first;
    logic                    w_d_first;
    logic [2:0]              w_a_op;
    logic [SIZE_BITS-1:0]    w_a_sz;
    logic [2:0]              w_d_op;
    logic [SIZE_BITS-1:0]    w_d_sz;
    logic [SOURCE_BITS-1:0]  w_d_src;
    logic                    w_a_last;
    logic                    w_d_last;
    logic                    w_a_new;
    logic                    w_d_new;
    logic                    w_d_clr;
    logic                    w_same_src;
    logic                    w_a_set;
    logic                    w_wd_clr;
    logic                    w_wd_inc;
    logic                    w_misaligned;
    logic                    w_mask_bad;
    logic                    w_a_beat_diff;
    logic                    w_d_beat_diff;
    logic                    w_snap_diff;
    logic [8:0]              w_err_p0;
    logic                    w_unused_d_denied;

    // d_denied carries no matching information; it is observed only.
    assign w_unused_d_denied = d_denied;

    assign w_fire_a  = a_valid & a_ready;
    assign w_fire_d  = d_valid & d_ready;
    assign w_a_first = (r_a_beat == '0);
    assign w_d_first = (r_d_beat == '0);

    // Later beats are framed by the latched first-beat header, not by the
    // (possibly corrupted) live inputs.
    assign w_a_op  = w_a_first ? a_opcode : r_a_opcode;
    assign w_a_sz  = w_a_first ? a_size   : r_a_size;
    assign w_d_op  = w_d_first ? d_opcode : r_d_opcode;
    assign w_d_sz  = w_d_first ? d_size   : r_d_size;
    assign w_d_src = w_d_first ? d_source : r_d_source;

    assign w_a_last = (r_a_beat == last_beat(a_has_data(w_a_op), w_a_sz));
    assign w_d_last = (r_d_beat == last_beat(w_d_op == D_ACKDATA, w_d_sz));

    assign w_a_new = w_fire_a & w_a_first;
    assign w_d_new = w_fire_d & w_d_first;

    // A D release and an A set on the same source in one cycle: the clear
    // applies first and the set wins, so the source is legitimately reused.
    assign w_d_clr    = w_fire_d & w_d_last & r_inflight[w_d_src];
    assign w_same_src = w_d_clr & (w_d_src == a_source);
    assign w_a_set    = w_a_new & (~r_inflight[a_source] | w_same_src);

    assign w_wd_clr = w_fire_d | (r_cnt == '0);
    assign w_wd_inc = ~w_wd_clr & (r_wd != WD_W'(WATCHDOG_CYCLES));

    assign w_misaligned = (a_address & ~({ADDR_BITS{1'b1}} << a_size)) != '0;
    assign w_mask_bad   = ((a_opcode == A_GET) || (a_opcode == A_PUTFULL)) &&
                          (int'(a_size) >= BEAT_LOG2) && (a_mask != {MASK_W{1'b1}});

    assign w_a_beat_diff = (a_opcode != r_a_opcode) || (a_param != r_a_param) ||
                           (a_size != r_a_size) || (a_source != r_a_source) ||
                           (a_address != r_a_address);
    assign w_d_beat_diff = (d_opcode != r_d_opcode) || (d_size != r_d_size) ||
                           (d_source != r_d_source);
    assign w_snap_diff   = (a_opcode != r_snap_opcode) || (a_param != r_snap_param) ||
                           (a_size != r_snap_size) || (a_source != r_snap_source) ||
                           (a_address != r_snap_address) || (a_mask != r_snap_mask);

    always_comb begin
        w_err_p0    = '0;
        w_err_p0[0] = w_a_new & param_illegal(a_opcode, a_param);
        w_err_p0[1] = w_a_new & (w_misaligned | w_mask_bad);
        w_err_p0[2] = w_a_new & r_inflight[a_source] & ~w_same_src;
        w_err_p0[3] = w_fire_a & ~w_a_first & w_a_beat_diff;
        w_err_p0[4] = w_d_new & ~r_inflight[d_source];
        // Response matching against stale per-source state is meaningless
        // for an orphan response, which class 4 already reports.
        w_err_p0[5] = w_d_new & ((d_opcode > D_HINTACK) |
                      (r_inflight[d_source] &
                       ((d_opcode != d_expected(r_expect[d_source], r_is_hint[d_source])) |
                        (d_size != r_src_size[d_source]))));
        w_err_p0[6] = w_fire_d & ~w_d_first & w_d_beat_diff;
        // Fires only on the step into saturation, so it is naturally one-shot
        // until the counter clears.
        w_err_p0[7] = w_wd_inc & (r_wd == WD_W'(WATCHDOG_CYCLES - 1));
        w_err_p0[8] = r_a_pend & (~a_valid | w_snap_diff);
    end

    // ------------------------------------------------------------------------
    // Stage p1: registered tracking state and error outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_a_beat        <= '0;
            r_a_opcode      <= '0;
            r_a_param       <= '0;
            r_a_size        <= '0;
            r_a_source      <= '0;
            r_a_address     <= '0;
            r_d_beat        <= '0;
            r_d_opcode      <= '0;
            r_d_size        <= '0;
            r_d_source      <= '0;
            r_a_pend        <= 1'b0;
            r_inflight      <= '0;
            r_expect        <= '0;
            r_cnt           <= '0;
            r_wd            <= '0;
            r_err_sticky_p1 <= '0;
            r_err_pulse_p1  <= 1'b0;
            r_err_first_p1  <= '0;
        end else begin
            if (w_fire_a) begin
                r_a_beat <= w_a_last ? '0 : r_a_beat + BW'(1);
                if (w_a_first) begin
                    r_a_opcode  <= a_opcode;
                    r_a_param   <= a_param;
                    r_a_size    <= a_size;
                    r_a_source  <= a_source;
                    r_a_address <= a_address;
                end
            end

            if (w_fire_d) begin
                r_d_beat <= w_d_last ? '0 : r_d_beat + BW'(1);
                if (w_d_first) begin
                    r_d_opcode <= d_opcode;
                    r_d_size   <= d_size;
                    r_d_source <= d_source;
                end
            end

            r_a_pend <= a_valid & ~a_ready;

            if (w_d_clr)
                r_inflight[w_d_src] <= 1'b0;
            if (w_a_new) begin
                r_inflight[a_source] <= 1'b1;
                r_expect[a_source]   <= a_wants_data(a_opcode);
            end

            r_cnt <= r_cnt + {{SOURCE_BITS{1'b0}}, w_a_set}
                           - {{SOURCE_BITS{1'b0}}, w_d_clr};

            if (w_wd_clr)
                r_wd <= '0;
            else if (w_wd_inc)
                r_wd <= r_wd + WD_W'(1);

            r_err_sticky_p1 <= r_err_sticky_p1 | w_err_p0;
            r_err_pulse_p1  <= |w_err_p0;
            if ((r_err_first_p1 == '0) && (|w_err_p0))
                r_err_first_p1 <= first_code(w_err_p0);
        end
    end

    // Per-source request attributes and the stall snapshot are plain data:
    // they are only read when qualified by the tracked control state.
    always_ff @(posedge clock) begin
        if (w_a_new) begin
            r_src_size[a_source] <= a_size;
            r_is_hint[a_source]  <= (a_opcode == A_HINT);
        end
        if (a_valid & ~a_ready) begin
            r_snap_opcode  <= a_opcode;
            r_snap_param   <= a_param;
            r_snap_size    <= a_size;
            r_snap_source  <= a_source;
            r_snap_address <= a_address;
            r_snap_mask    <= a_mask;
        end
    end

    assign err_sticky   = r_err_sticky_p1;
    assign err_pulse    = r_err_pulse_p1;
    assign err_first    = r_err_first_p1;
    assign inflight_cnt = r_cnt;

`ifdef TL_UL_CHECKER_FATAL_EN
    function automatic string err_name(input int idx);
        case (idx)
            0:       return "ILLEGAL_OPCODE_PARAM";
            1:       return "ALIGN_OR_MASK";
            2:       return "SOURCE_IN_FLIGHT";
            3:       return "A_BEAT_MISMATCH";
            4:       return "D_NOT_IN_FLIGHT";
            5:       return "D_OPCODE_SIZE";
            6:       return "D_BEAT_MISMATCH";
            7:       return "WATCHDOG";
            default: return "A_VALID_HOLD";
        endcase
    endfunction

    logic [31:0] r_cycle;

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_cycle <= '0;
        else
            r_cycle <= r_cycle + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 9; i++) begin
                if (w_err_p0[i]) begin
                    $error("tl_ul_protocol_checker: %s source %0d cycle %0d",
                           err_name(i),
                           (i >= 4 && i <= 6) ? d_source : a_source, r_cycle);
                    if (i == 2 || i == 4 || i == 7)
                        $fatal(1, "tl_ul_protocol_checker: fatal class %s", err_name(i));
                end
            end
        end
    end
`else
    // Flags only: violations are reported solely through the error outputs.
`endif

endmodule
